ser4_tx: RTL



---
 rtl/ser4_tx.sv | 111 +++++++++++
 1 files changed

// File: rtl/ser4_tx.sv
// 4:1 transmit serializer: streams 4-beat words, fill words and a bit-slip training sequence onto WIDTH lanes.
// Optional build macro SER4_IDLE_PAT_EN: fill words carry IDLE_PAT on every lane instead of zeros.
module ser4_tx #(
    parameter int          WIDTH       = 2,
    parameter int          TRAIN_WORDS = 16,
    parameter logic [3:0]  TRAIN_PAT   = 4'b0011,
    parameter logic [3:0]  IDLE_PAT    = 4'b0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 calib_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [4*WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]     q_o,
    output logic                 frame_o,
    output logic                 train_o,
    output logic                 train_done_o
);
    typedef enum logic [1:0] {IDLE, DATA, TRAIN} state_t;

    // Replicates a 4-bit per-beat pattern across all lanes, bit k on beat k.
    function automatic logic [4*WIDTH-1:0] pat_word(input logic [3:0] p);
        logic [4*WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[k*WIDTH +: WIDTH] = {WIDTH{p[k]}};
        end
        return w;
    endfunction

    localparam logic [4*WIDTH-1:0] TRAIN_WORD = pat_word(TRAIN_PAT);
`ifdef SER4_IDLE_PAT_EN
    localparam logic [4*WIDTH-1:0] FILL_WORD = pat_word(IDLE_PAT);
`else
    // IDLE_PAT is masked off so the fill word is all zeros in this build.
    localparam logic [4*WIDTH-1:0] FILL_WORD = pat_word(IDLE_PAT & 4'b0000);
`endif

    state_t             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic               pend_q, pend_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4*WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               frame_q, train_q;

    logic boundary, train_req, last_train, xfer;

    assign boundary   = (beat_q == 2'd3);
    assign train_req  = pend_q | calib_i;
    assign last_train = (state_q == TRAIN) && (cnt_q == 8'd1);
    // The final training boundary may accept data so the stream continues without a gap.
    assign ready_o    = boundary & ((state_q != TRAIN) | last_train) & ~pend_q & ~calib_i & ~reset;
    assign xfer       = valid_i & ready_o;
    assign train_done_o = boundary & last_train & ~train_req & ~reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | calib_i;
        beat_d  = beat_q + 2'd1;
        sh_d    = sh_q >> WIDTH;
        if (boundary) begin
            if (train_req) begin
                state_d = TRAIN;
                cnt_d   = 8'(TRAIN_WORDS);
                pend_d  = 1'b0;
                sh_d    = TRAIN_WORD;
            end else if ((state_q == TRAIN) && !last_train) begin
                cnt_d = cnt_q - 8'd1;
                sh_d  = TRAIN_WORD;
            end else if (xfer) begin
                state_d = DATA;
                cnt_d   = 8'd0;
                sh_d    = data_i;
            end else begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                sh_d    = FILL_WORD;
            end
        end
        q_d = sh_d[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= 2'd3;
            pend_q  <= 1'b0;
            cnt_q   <= 8'd0;
            sh_q    <= '0;
            q_q     <= '0;
            frame_q <= 1'b0;
            train_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            q_q     <= q_d;
            frame_q <= boundary;
            train_q <= (state_d == TRAIN);
        end
    end

    assign q_o     = q_q;
    assign frame_o = frame_q;
    assign train_o = train_q;
endmodule
